// File: rtl/axil_timeout_pkg.sv
// Shared types and constants for the AXI-Lite timeout shield.
package axil_timeout_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, BACK} chan_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Counter width able to hold 0..n-1.
  function automatic int TO_CNT_W(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/axil_timeout_ctr.sv
// Per-channel watchdog: cleared on request issue, counts while enabled,
// flags the last allowed cycle.
module axil_timeout_ctr
  import axil_timeout_pkg::*;
#(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = TO_CNT_W(LIMIT);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign expire = en && (cnt == LAST);
endmodule

// File: rtl/axil_timeout_shield.sv
// AXI-Lite guard in front of an untrusted slave: one write and one read in
// flight, SLVERR + sticky trip on timeout. `AXIL_TIMEOUT_CNT_EN adds timeout_count.
module axil_timeout_shield
  import axil_timeout_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_lite_s_awaddr,
  input  logic                      axi_lite_s_awvalid,
  output logic                      axi_lite_s_awready,
  input  logic [31:0]               axi_lite_s_wdata,
  input  logic [3:0]                axi_lite_s_wstrb,
  input  logic                      axi_lite_s_wvalid,
  output logic                      axi_lite_s_wready,
  output logic [1:0]                axi_lite_s_bresp,
  output logic                      axi_lite_s_bvalid,
  input  logic                      axi_lite_s_bready,
  input  logic [AXI_ADDR_WIDTH-1:0] axi_lite_s_araddr,
  input  logic                      axi_lite_s_arvalid,
  output logic                      axi_lite_s_arready,
  output logic [31:0]               axi_lite_s_rdata,
  output logic [1:0]                axi_lite_s_rresp,
  output logic                      axi_lite_s_rvalid,
  input  logic                      axi_lite_s_rready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_lite_m_awaddr,
  output logic                      axi_lite_m_awvalid,
  input  logic                      axi_lite_m_awready,
  output logic [31:0]               axi_lite_m_wdata,
  output logic [3:0]                axi_lite_m_wstrb,
  output logic                      axi_lite_m_wvalid,
  input  logic                      axi_lite_m_wready,
  input  logic [1:0]                axi_lite_m_bresp,
  input  logic                      axi_lite_m_bvalid,
  output logic                      axi_lite_m_bready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_lite_m_araddr,
  output logic                      axi_lite_m_arvalid,
  input  logic                      axi_lite_m_arready,
  input  logic [31:0]               axi_lite_m_rdata,
  input  logic [1:0]                axi_lite_m_rresp,
  input  logic                      axi_lite_m_rvalid,
  output logic                      axi_lite_m_rready,
  output logic                      timeout_tripped,
  input  logic                      clear_trip
`ifdef AXIL_TIMEOUT_CNT_EN
  ,output logic [15:0]              timeout_count
`endif
);
  chan_state_t w_st, r_st;
  logic trip_q;
  logic aw_q, w_q, ar_q;
  logic s_bvalid_q, s_rvalid_q;
  logic [1:0] bresp_q, rresp_q;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [3:0] wstrb_q;

  logic w_acc, r_acc, aw_hs, w_hs, ar_hs;
  logic w_lim, r_lim, w_exp, r_exp;

  // Both s-side readies pulse together so aw and w are never split.
  assign w_acc = aresetn && (w_st == IDLE) && axi_lite_s_awvalid && axi_lite_s_wvalid;
  assign r_acc = aresetn && (r_st == IDLE) && axi_lite_s_arvalid;

  assign axi_lite_s_awready = w_acc;
  assign axi_lite_s_wready  = w_acc;
  assign axi_lite_s_arready = r_acc;

  // Pending requests are masked while tripped; the watchdog then ends them.
  assign axi_lite_m_awvalid = aw_q && !trip_q;
  assign axi_lite_m_wvalid  = w_q  && !trip_q;
  assign axi_lite_m_arvalid = ar_q && !trip_q;
  assign axi_lite_m_bready  = (w_st == RESP) || trip_q;
  assign axi_lite_m_rready  = (r_st == RESP) || trip_q;

  assign aw_hs = axi_lite_m_awvalid && axi_lite_m_awready;
  assign w_hs  = axi_lite_m_wvalid  && axi_lite_m_wready;
  assign ar_hs = axi_lite_m_arvalid && axi_lite_m_arready;

  // A real response in the last allowed cycle beats the timeout.
  assign w_exp = w_lim && !((w_st == RESP) && axi_lite_m_bvalid);
  assign r_exp = r_lim && !((r_st == RESP) && axi_lite_m_rvalid);

  axil_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_wctr (
    .clk(aclk), .rst_n(aresetn), .clr(w_acc && !trip_q),
    .en((w_st == REQ) || (w_st == RESP)), .expire(w_lim)
  );
  axil_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_rctr (
    .clk(aclk), .rst_n(aresetn), .clr(r_acc && !trip_q),
    .en((r_st == REQ) || (r_st == RESP)), .expire(r_lim)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_st <= IDLE; aw_q <= 1'b0; w_q <= 1'b0; s_bvalid_q <= 1'b0;
      bresp_q <= RESP_OKAY; awaddr_q <= '0; wdata_q <= '0; wstrb_q <= '0;
    end else begin
      case (w_st)
        IDLE: if (w_acc) begin
          awaddr_q <= axi_lite_s_awaddr;
          wdata_q  <= axi_lite_s_wdata;
          wstrb_q  <= axi_lite_s_wstrb;
          if (trip_q) begin
            w_st <= BACK; s_bvalid_q <= 1'b1; bresp_q <= RESP_SLVERR;
          end else begin
            w_st <= REQ; aw_q <= 1'b1; w_q <= 1'b1;
          end
        end
        REQ: if (w_exp) begin
          aw_q <= 1'b0; w_q <= 1'b0;
          w_st <= BACK; s_bvalid_q <= 1'b1; bresp_q <= RESP_SLVERR;
        end else begin
          if (aw_hs) aw_q <= 1'b0;
          if (w_hs)  w_q  <= 1'b0;
          if ((!aw_q || aw_hs) && (!w_q || w_hs)) w_st <= RESP;
        end
        RESP: if (axi_lite_m_bvalid) begin
          w_st <= BACK; s_bvalid_q <= 1'b1; bresp_q <= axi_lite_m_bresp;
        end else if (w_exp) begin
          w_st <= BACK; s_bvalid_q <= 1'b1; bresp_q <= RESP_SLVERR;
        end
        BACK: if (axi_lite_s_bready) begin
          w_st <= IDLE; s_bvalid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_st <= IDLE; ar_q <= 1'b0; s_rvalid_q <= 1'b0;
      rresp_q <= RESP_OKAY; rdata_q <= '0; araddr_q <= '0;
    end else begin
      case (r_st)
        IDLE: if (r_acc) begin
          araddr_q <= axi_lite_s_araddr;
          if (trip_q) begin
            r_st <= BACK; s_rvalid_q <= 1'b1; rresp_q <= RESP_SLVERR; rdata_q <= '0;
          end else begin
            r_st <= REQ; ar_q <= 1'b1;
          end
        end
        REQ: if (r_exp) begin
          ar_q <= 1'b0;
          r_st <= BACK; s_rvalid_q <= 1'b1; rresp_q <= RESP_SLVERR; rdata_q <= '0;
        end else if (ar_hs) begin
          ar_q <= 1'b0; r_st <= RESP;
        end
        RESP: if (axi_lite_m_rvalid) begin
          r_st <= BACK; s_rvalid_q <= 1'b1;
          rresp_q <= axi_lite_m_rresp; rdata_q <= axi_lite_m_rdata;
        end else if (r_exp) begin
          r_st <= BACK; s_rvalid_q <= 1'b1; rresp_q <= RESP_SLVERR; rdata_q <= '0;
        end
        BACK: if (axi_lite_s_rready) begin
          r_st <= IDLE; s_rvalid_q <= 1'b0;
        end
      endcase
    end
  end

  // Clear is honoured only with both channels idle; set wins otherwise.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                                          trip_q <= 1'b0;
    else if (w_exp || r_exp)                               trip_q <= 1'b1;
    else if (clear_trip && w_st == IDLE && r_st == IDLE)   trip_q <= 1'b0;
  end

`ifdef AXIL_TIMEOUT_CNT_EN
  logic [15:0] cnt_q;
  logic [16:0] cnt_sum;
  assign cnt_sum = {1'b0, cnt_q} + 17'(w_exp) + 17'(r_exp);
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) cnt_q <= '0;
    else          cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
  assign timeout_count = cnt_q;
`endif

  assign timeout_tripped    = trip_q;
  assign axi_lite_s_bvalid  = s_bvalid_q;
  assign axi_lite_s_bresp   = bresp_q;
  assign axi_lite_s_rvalid  = s_rvalid_q;
  assign axi_lite_s_rresp   = rresp_q;
  assign axi_lite_s_rdata   = rdata_q;
  assign axi_lite_m_awaddr  = awaddr_q;
  assign axi_lite_m_wdata   = wdata_q;
  assign axi_lite_m_wstrb   = wstrb_q;
  assign axi_lite_m_araddr  = araddr_q;
endmodule

// File: tb/tb_axil_timeout_shield.sv
// Directed + randomized bench for axil_timeout_shield; the expected response,
// latency and trip state come from a cycle-arithmetic model of the slave.
module tb_axil_timeout_shield;
  localparam int T = 16;
  localparam int HANG = 100;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
  logic [3:0]  s_wstrb = '0;
  logic s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata = '0;
  logic [3:0]  m_wstrb;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0;
  logic [1:0] m_bresp = '0, m_rresp = '0;
  logic timeout_tripped, clear_trip = 0;
`ifdef AXIL_TIMEOUT_CNT_EN
  logic [15:0] timeout_count;
`endif

  int total = 0, bad = 0;
  bit trip_m = 0;
  int cnt_m = 0;

  axil_timeout_shield #(.AXI_ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .axi_lite_s_awaddr(s_awaddr), .axi_lite_s_awvalid(s_awvalid), .axi_lite_s_awready(s_awready),
    .axi_lite_s_wdata(s_wdata), .axi_lite_s_wstrb(s_wstrb), .axi_lite_s_wvalid(s_wvalid),
    .axi_lite_s_wready(s_wready), .axi_lite_s_bresp(s_bresp), .axi_lite_s_bvalid(s_bvalid),
    .axi_lite_s_bready(s_bready), .axi_lite_s_araddr(s_araddr), .axi_lite_s_arvalid(s_arvalid),
    .axi_lite_s_arready(s_arready), .axi_lite_s_rdata(s_rdata), .axi_lite_s_rresp(s_rresp),
    .axi_lite_s_rvalid(s_rvalid), .axi_lite_s_rready(s_rready),
    .axi_lite_m_awaddr(m_awaddr), .axi_lite_m_awvalid(m_awvalid), .axi_lite_m_awready(m_awready),
    .axi_lite_m_wdata(m_wdata), .axi_lite_m_wstrb(m_wstrb), .axi_lite_m_wvalid(m_wvalid),
    .axi_lite_m_wready(m_wready), .axi_lite_m_bresp(m_bresp), .axi_lite_m_bvalid(m_bvalid),
    .axi_lite_m_bready(m_bready), .axi_lite_m_araddr(m_araddr), .axi_lite_m_arvalid(m_arvalid),
    .axi_lite_m_arready(m_arready), .axi_lite_m_rdata(m_rdata), .axi_lite_m_rresp(m_rresp),
    .axi_lite_m_rvalid(m_rvalid), .axi_lite_m_rready(m_rready),
    .timeout_tripped(timeout_tripped), .clear_trip(clear_trip)
`ifdef AXIL_TIMEOUT_CNT_EN
    , .timeout_count(timeout_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(); @(posedge aclk); #1; endtask
  task automatic to_neg(); @(negedge aclk); endtask

  task automatic chk_cnt();
`ifdef AXIL_TIMEOUT_CNT_EN
    chk("timeout_count", timeout_count, cnt_m[15:0]);
`endif
  endtask

  task automatic pulse_clear();
    clear_trip = 1; step(); clear_trip = 0;
    trip_m = 0;
    to_neg(); chk("clear_trip", timeout_tripped, trip_m); step();
  endtask

  // Slave behaviour: aw ready da cycles after issue, w ready dw cycles after,
  // b valid db cycles after RESP is entered (cycle max(da,dw)+1).
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int da,
                          input int dw, input int db, input logic [1:0] sresp,
                          input int stall, input bit clr_in_back);
    int kb, kexp, kobs; bit fwd, ok, acc, aw_done, w_done, b_sent; logic [1:0] eresp;
    fwd = !trip_m;
    kb = ((da > dw) ? da : dw) + 1 + db;
    ok = fwd && (kb <= T - 1);
    kexp = !fwd ? 0 : (ok ? kb + 1 : T);
    eresp = ok ? sresp : 2'b10;
    s_awaddr = addr; s_wdata = data; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    acc = 0;
    for (int i = 0; i < 8 && !acc; i++) begin
      to_neg(); if (s_awready && s_wready) acc = 1; step();
    end
    chk("w_accept", acc, 1);
    s_awvalid = 0; s_wvalid = 0;
    kobs = -1; aw_done = 0; w_done = 0; b_sent = 0;
    for (int k = 0; k < T + 8 && kobs < 0; k++) begin
      m_awready = !aw_done && k >= da; m_wready = !w_done && k >= dw;
      m_bvalid = !b_sent && k >= kb; m_bresp = sresp;
      to_neg();
      if (k == 0) begin
        chk("w_m_valids", {m_awvalid, m_wvalid}, {fwd, fwd});
        if (fwd) chk("w_m_addr_data", {m_awaddr, m_wdata}, {addr, data});
      end
      if (m_awvalid && m_awready) aw_done = 1;
      if (m_wvalid && m_wready) w_done = 1;
      if (m_bvalid && m_bready) b_sent = 1;
      if (s_bvalid) kobs = k;
      step();
    end
    m_awready = 0; m_wready = 0; m_bvalid = 0;
    chk("w_latency", kobs, kexp);
    chk("w_bresp", s_bresp, eresp);
    if (fwd && !ok) chk("w_m_dropped", {m_awvalid, m_wvalid}, 2'b00);
    for (int j = 0; j < stall; j++) begin
      if (clr_in_back && j == 0) clear_trip = 1;
      to_neg(); chk("w_back_hold", s_bvalid, 1); step();
      clear_trip = 0;
    end
    s_bready = 1; to_neg(); step(); s_bready = 0;
    to_neg(); chk("w_b_done", s_bvalid, 0); step();
    if (fwd && !ok) begin trip_m = 1; cnt_m++; end
    chk("w_tripped", timeout_tripped, trip_m);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] sdata, input int da,
                         input int db, input logic [1:0] sresp, input int stall);
    int kb, kexp, kobs; bit fwd, ok, acc, ar_done, r_sent; logic [1:0] eresp; logic [31:0] edata;
    fwd = !trip_m;
    kb = da + 1 + db;
    ok = fwd && (kb <= T - 1);
    kexp = !fwd ? 0 : (ok ? kb + 1 : T);
    eresp = ok ? sresp : 2'b10;
    edata = ok ? sdata : 32'h0;
    s_araddr = addr; s_arvalid = 1;
    acc = 0;
    for (int i = 0; i < 8 && !acc; i++) begin
      to_neg(); if (s_arready) acc = 1; step();
    end
    chk("r_accept", acc, 1);
    s_arvalid = 0;
    kobs = -1; ar_done = 0; r_sent = 0;
    for (int k = 0; k < T + 8 && kobs < 0; k++) begin
      m_arready = !ar_done && k >= da;
      m_rvalid = !r_sent && k >= kb; m_rdata = sdata; m_rresp = sresp;
      to_neg();
      if (k == 0) begin
        chk("r_m_valid", m_arvalid, fwd);
        if (fwd) chk("r_m_addr", m_araddr, addr);
      end
      if (m_arvalid && m_arready) ar_done = 1;
      if (m_rvalid && m_rready) r_sent = 1;
      if (s_rvalid) kobs = k;
      step();
    end
    m_arready = 0; m_rvalid = 0;
    chk("r_latency", kobs, kexp);
    chk("r_resp_data", {s_rresp, s_rdata}, {eresp, edata});
    if (fwd && !ok) chk("r_m_dropped", m_arvalid, 0);
    for (int j = 0; j < stall; j++) begin
      to_neg(); chk("r_back_hold", s_rvalid, 1); step();
    end
    s_rready = 1; to_neg(); step(); s_rready = 0;
    to_neg(); chk("r_done", s_rvalid, 0); step();
    if (fwd && !ok) begin trip_m = 1; cnt_m++; end
    chk("r_tripped", timeout_tripped, trip_m);
  endtask

  initial begin
    // reset state
    repeat (3) step();
    to_neg();
    chk("rst_s_side", {s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp}, 0);
    chk("rst_m_side", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    chk("rst_data", {m_awaddr, m_wdata, s_rdata}, 0);
    chk("rst_tripped", timeout_tripped, 0);
    step(); aresetn = 1; step();
    chk_cnt();

    // basic forwarded write, OKAY after 3 cycles
    do_write(32'h10, 32'hA5A5_A5A5, 0, 0, 3, 2'b00, 0, 0);
    // slave never takes aw -> timeout, trip
    do_write(32'h14, 32'h1234_5678, HANG, 0, 0, 2'b00, 1, 0);
    chk_cnt();
    // read while tripped answered locally, then a stale rvalid drains
    do_read(32'h20, 32'hCAFE_F00D, 0, 0, 2'b00, 0);
    m_rvalid = 1; m_rdata = 32'hDEAD_BEEF; to_neg();
    chk("stale_rready", m_rready, 1); step(); m_rvalid = 0;
    to_neg(); chk("stale_quiet", s_rvalid, 0); step();
    // clear during stalled BACK is ignored, clear in IDLE works
    do_write(32'h24, 32'h0, 0, 0, 0, 2'b00, 3, 1);
    pulse_clear();
    do_write(32'h28, 32'h5555_AAAA, 1, 2, 0, 2'b01, 0, 0);
    // response exactly in the timeout cycle wins
    do_read(32'h2C, 32'h0BAD_CAFE, 0, T - 2, 2'b00, 0);
    // write one cycle beyond the budget
    do_write(32'h30, 32'h7, 0, 0, T - 1, 2'b00, 0, 0);
    chk_cnt();
    pulse_clear();
    // simultaneous read + write timeout
    fork
      do_write(32'h34, 32'h9, HANG, HANG, 0, 2'b00, 0, 0);
      do_read(32'h38, 32'h9, HANG, 0, 2'b00, 0);
    join
    chk_cnt();
    pulse_clear();

    // randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      int da, dw, db;
      da = ($urandom_range(0, 5) == 0) ? HANG : $urandom_range(0, 4);
      dw = $urandom_range(0, 4);
      db = $urandom_range(0, 13);
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, $urandom, da, dw, db, 2'($urandom_range(0, 3)), $urandom_range(0, 2), 0);
      else
        do_read($urandom, $urandom, da, db, 2'($urandom_range(0, 3)), $urandom_range(0, 2));
      if (trip_m && $urandom_range(0, 1) == 1) pulse_clear();
    end
    chk_cnt();
    if (trip_m) pulse_clear();

    // reset in the middle of a forwarded write
    s_awaddr = 32'h40; s_wdata = 32'h1; s_awvalid = 1; s_wvalid = 1;
    to_neg(); chk("mid_accept", s_awready, 1); step();
    s_awvalid = 0; s_wvalid = 0;
    to_neg(); chk("mid_req", m_awvalid, 1);
    aresetn = 0; #1;
    chk("mid_rst_valids", {m_awvalid, m_wvalid, m_bready, s_bvalid, s_awready, timeout_tripped}, 0);
    chk("mid_rst_data", {m_awaddr, m_wdata}, 0);
    trip_m = 0; cnt_m = 0;
    step(); step(); aresetn = 1; step();
    chk_cnt();
    do_write(32'h44, 32'hFEED_0001, 0, 0, 0, 2'b00, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
